serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 143 ++++++++++++++
 tb/tb_serial_addsub.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, valid/ready on both sides.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic a_bit, b_bit, s_bit, chain_out, last_bit;

    assign a_bit     = a_q[cnt_q];
    assign b_bit     = b_q[cnt_q];
    assign s_bit     = a_bit ^ b_bit ^ c_q;
    assign chain_out = mode_q ? ((~a_bit & b_bit) | (~(a_bit ^ b_bit) & c_q))
                              : ((a_bit & b_bit) | (b_bit & c_q) | (a_bit & c_q));
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    // State register plus datapath registers.
    // NOTE: reset is synchronous, so it lives inside the clocked block and is
    // only seen at a rising edge; every register here gets a defined reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state logic.
    // NOTE: combinational blocks assign a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: handshakes depend on state alone.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: capture on accept, one bit per RUN cycle.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (state_q == IDLE && in_valid) begin
            a_d    = a;
            b_d    = b;
            c_d    = cin;
            mode_d = mode;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            result_d[cnt_q] = s_bit;
            c_d             = chain_out;
            if (!last_bit) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cout_d = chain_out;
`ifdef SERIAL_ADDSUB_OVF_EN
                // At the last bit a_bit/b_bit/s_bit are the sign bits.
                ovf_d = mode_q ? ((a_bit != b_bit) && (s_bit != a_bit))
                               : ((a_bit == b_bit) && (s_bit != a_bit));
`endif
            end
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed, table-driven bench for serial_addsub (WIDTH=8 and WIDTH=16 instances).
// Overflow is only compared when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0, mode8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, cout8;
    logic [7:0] result8;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic       ovf8, ovf16;
`endif

    // WIDTH=16 instance
    logic        in_valid16 = 1'b0, out_ready16 = 1'b0, cin16 = 1'b0, mode16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, cout16;
    logic [15:0] result16;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .mode(mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .cout(cout8)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .mode(mode16), .out_valid(out_valid16),
        .out_ready(out_ready16), .result(result16), .cout(cout16)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf16)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       mode;
        logic [7:0] exp_result;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set on dut8, scramble inputs while it runs, check latency and result.
    task automatic run_op8(input vec_t v, input string tag, input bit release_now);
        int lat;
        check({tag, " in_ready before accept"}, 64'(in_ready8), 64'd1);
        a8 = v.a; b8 = v.b; cin8 = v.cin; mode8 = v.mode; in_valid8 = 1'b1;
        tick();
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom); mode8 = 1'($urandom);
            in_valid8 = 1'($urandom); out_ready8 = 1'($urandom);
            tick();
            lat++;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " result"}, 64'(result8), 64'(v.exp_result));
        check({tag, " cout"}, 64'(cout8), 64'(v.exp_cout));
`ifdef SERIAL_ADDSUB_OVF_EN
        check({tag, " ovf"}, 64'(ovf8), 64'(v.exp_ovf));
`endif
        if (release_now) begin
            out_ready8 = 1'b1;
            tick();
            out_ready8 = 1'b0;
            check({tag, " in_ready after release"}, 64'(in_ready8), 64'd1);
            check({tag, " out_valid after release"}, 64'(out_valid8), 64'd0);
        end
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        vec_t v;
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0};
        vecs[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1};

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset in_ready", 64'(in_ready8), 64'd1);
        check("reset out_valid", 64'(out_valid8), 64'd0);
        check("reset result", 64'(result8), 64'd0);
        check("reset cout", 64'(cout8), 64'd0);
        check("reset in_ready16", 64'(in_ready16), 64'd1);

        for (int i = 0; i < 10; i++) begin
            run_op8(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Hold the result in DONE while the inputs churn.
        v = vecs[5];
        run_op8(v, "hold", 1'b0);
        for (int k = 0; k < 5; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = ~in_valid8;
            tick();
            check($sformatf("hold result c%0d", k), 64'(result8), 64'h46);
            check($sformatf("hold in_ready c%0d", k), 64'(in_ready8), 64'd0);
            check($sformatf("hold out_valid c%0d", k), 64'(out_valid8), 64'd1);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check("hold release in_ready", 64'(in_ready8), 64'd1);
        check("hold release out_valid", 64'(out_valid8), 64'd0);

        // Reset while bit 3 is in flight aborts the operation.
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; mode8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick(); tick(); tick();
        check("abort still running", 64'(in_ready8), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort in_ready", 64'(in_ready8), 64'd1);
        check("abort out_valid", 64'(out_valid8), 64'd0);
        check("abort result", 64'(result8), 64'd0);
        check("abort cout", 64'(cout8), 64'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("abort ovf", 64'(ovf8), 64'd0);
`endif
        lat = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid8) lat++;
        end
        check("abort no out_valid", 64'(lat), 64'd0);
        run_op8(vecs[5], "after abort", 1'b1);

        // WIDTH=16 carry ripples through every bit.
        a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; mode16 = 1'b0; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; mode16 = 1'b1;
        lat = 0;
        while (!out_valid16 && lat < 60) begin
            tick();
            lat++;
        end
        check("w16 latency", 64'(lat), 64'd16);
        check("w16 result", 64'(result16), 64'h0000);
        check("w16 cout", 64'(cout16), 64'd1);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("w16 ovf", 64'(ovf16), 64'd0);
`endif
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        check("w16 in_ready after release", 64'(in_ready16), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
